// File: rtl/cal_pkg.sv
// Shared encodings for the calculator stack: operation select and FSM states.
package cal_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MAX = 2'b10,
    OP_MIN = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/cal_alu.sv
// Combinational accumulator step: y = a OP b, all signed and ACC_W wide.
//   op : operation select (ADD, SUB, MAX, MIN)
//   a  : running accumulator
//   b  : sign-extended stack operand
//   y  : next accumulator value
module cal_alu
  import cal_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  op_e                     op,
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MAX:  y = (a > b) ? a : b;
      OP_MIN:  y = (a < b) ? a : b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/cal_stack.sv
// Operand stack with a sequential reducer. Rising edges of load push samples,
// a rising edge of exec folds the held operands left-to-right with one ALU step
// per cycle, and a rising edge of clear empties the stack and zeroes result.
//   clk, reset          : clock, asynchronous active-high reset
//   load, exec, clear   : level requests, acted on at their rising edge
//   op, sample          : operation select, signed operand to push
//   result              : signed result of the last completed calculation
//   count, empty, full  : stack occupancy
//   busy, done, err     : RUN state, result-updated pulse, rejected-request pulse
module cal_stack
  import cal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int ACC_W = WIDTH + $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         exec,
  input  logic                         clear,
  input  logic [1:0]                   op,
  input  logic signed [WIDTH-1:0]      sample,
  output logic signed [ACC_W-1:0]      result,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  state_e                   state_q, state_d;
  logic signed [WIDTH-1:0]  stk [DEPTH];
  logic signed [ACC_W-1:0]  acc, alu_y;
  logic [IW-1:0]            idx;
  op_e                      op_q;
  logic                     load_q, exec_q, clear_q;
  logic                     load_e, exec_e, clear_e;
  logic                     start, finish, exec_err;
  logic                     load_ok, load_err;
  logic [IW-1:0]            wr_ptr;

  assign load_e  = load  & ~load_q;
  assign exec_e  = exec  & ~exec_q;
  assign clear_e = clear & ~clear_q;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign busy   = (state_q == S_RUN);
  // Only used when not full, so the truncation never aliases a live slot.
  assign wr_ptr = count[IW-1:0];

  // Exec wins over a coincident load in IDLE; in RUN any load is rejected.
  assign load_ok  = load_e & ~clear_e & ~busy & ~exec_e & ~full;
  assign load_err = load_e & ~clear_e & (busy | (~exec_e & full));

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    finish   = 1'b0;
    exec_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exec_e) begin
          if (count >= CW'(2)) begin
            start   = 1'b1;
            state_d = S_RUN;
          end else begin
            exec_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (idx == IW'(count - CW'(1))) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_e) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  cal_alu #(.ACC_W(ACC_W)) u_alu (
    .op (op_q),
    .a  (acc),
    .b  (ACC_W'(stk[idx])),
    .y  (alu_y)
  );

  // Stack storage carries no reset; contents are meaningless past count.
  always_ff @(posedge clk) begin
    if (load_ok) stk[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= 1'b0;
      exec_q  <= 1'b0;
      clear_q <= 1'b0;
      count   <= '0;
      result  <= '0;
      acc     <= '0;
      idx     <= '0;
      op_q    <= OP_ADD;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      load_q  <= load;
      exec_q  <= exec;
      clear_q <= clear;
      done    <= finish & ~clear_e;
      err     <= ~clear_e & (exec_err | load_err);
      if (clear_e) begin
        count  <= '0;
        result <= '0;
      end else begin
        if (load_ok) count <= count + CW'(1);
        if (start) begin
          acc  <= ACC_W'(stk[0]);
          idx  <= IW'(1);
          op_q <= op_e'(op);
        end else if (busy) begin
          acc <= alu_y;
          idx <= idx + IW'(1);
          if (finish) result <= alu_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_cal_stack.sv
module tb_cal_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int ACC_W = WIDTH + $clog2(DEPTH);

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     load = 1'b0, exec = 1'b0, clear = 1'b0;
  logic [1:0]               op = 2'b00;
  logic signed [WIDTH-1:0]  sample = '0;
  logic signed [ACC_W-1:0]  result;
  logic [2:0]               count;
  logic                     empty, full, busy, done, err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  cal_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .load(load), .exec(exec), .clear(clear),
    .op(op), .sample(sample), .result(result), .count(count),
    .empty(empty), .full(full), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the whole reduction is computed at exec time from the
  // queue; busy time is just a countdown of size-1 cycles.
  int  stk_m[$];
  int  res_m, pend_m, left_m;
  bit  done_m, err_m, lq, eq, cq, le, ee, ce;

  function automatic int fold(input int q[$], input logic [1:0] o);
    int a;
    a = q[0];
    for (int i = 1; i < q.size(); i++)
      case (o)
        2'd0: a = a + q[i];
        2'd1: a = a - q[i];
        2'd2: if (q[i] > a) a = q[i];
        default: if (q[i] < a) a = q[i];
      endcase
    return a;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_m.delete();
      res_m = 0; pend_m = 0; left_m = 0;
      done_m = 0; err_m = 0; lq = 0; eq = 0; cq = 0;
    end else begin
      le = load && !lq; ee = exec && !eq; ce = clear && !cq;
      lq = load; eq = exec; cq = clear;
      done_m = 0; err_m = 0;
      if (ce) begin
        stk_m.delete(); res_m = 0; left_m = 0;
      end else if (left_m > 0) begin
        if (le) err_m = 1;
        left_m--;
        if (left_m == 0) begin res_m = pend_m; done_m = 1; end
      end else if (ee) begin
        if (stk_m.size() >= 2) begin
          pend_m = fold(stk_m, op);
          left_m = stk_m.size() - 1;
        end else err_m = 1;
      end else if (le) begin
        if (stk_m.size() == DEPTH) err_m = 1;
        else stk_m.push_back(int'(sample));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("result", longint'(result), res_m);
      chk("count", count, stk_m.size());
      chk("empty", empty, stk_m.size() == 0);
      chk("full", full, stk_m.size() == DEPTH);
      chk("busy", busy, left_m > 0);
      chk("done", done, done_m);
      chk("err", err, err_m);
    end
  end

  task automatic drive(input bit l, input bit e, input bit c, input logic [1:0] o, input int s);
    @(negedge clk);
    load = l; exec = e; clear = c; op = o; sample = WIDTH'(s);
  endtask

  task automatic push(input int v);
    drive(1, 0, 0, op, v);
    drive(0, 0, 0, op, v);
  endtask

  task automatic do_clear();
    drive(0, 0, 1, op, 0);
    drive(0, 0, 0, op, 0);
  endtask

  // Raise exec (optionally with load), then expect n-1 busy cycles, a done
  // pulse and the literal result.
  task automatic run(input string nm, input logic [1:0] o, input bit with_load,
                     input int n, input int exp);
    drive(with_load, 1, 0, o, 99);
    drive(0, 0, 0, o, 0);
    chk({nm, "_err"}, err, 0);
    for (int k = 0; k < n - 1; k++) begin
      chk({nm, "_busy"}, busy, 1);
      @(negedge clk);
    end
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_result"}, longint'(result), exp);
    chk({nm, "_count"}, count, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", longint'(result), 0);
    reset = 1'b0;
    cmp_en = 1'b1;

    push(5); push(-3); push(10);
    run("add3", 2'd0, 0, 3, 12);
    do_clear();
    chk("clr_result", longint'(result), 0);
    chk("clr_empty", empty, 1);

    push(100); push(30); push(80);
    run("sub3", 2'd1, 0, 3, -10);
    do_clear();
    push(7); push(-2); push(9); push(0);
    run("min4", 2'd3, 0, 4, -2);
    run("max4", 2'd2, 0, 4, 9);
    do_clear();

    for (int i = 0; i < 4; i++) push(-32768);
    run("addneg", 2'd0, 0, 4, -131072);
    drive(1, 0, 0, op, 1234);
    drive(0, 0, 0, op, 0);
    chk("ovf_err", err, 1);
    chk("ovf_count", count, 4);

    drive(0, 1, 0, 2'd0, 0);
    drive(0, 0, 1, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", longint'(result), 0);
    chk("abort_empty", empty, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done2", done, 0);

    push(4); push(6);
    run("ldex", 2'd0, 1, 2, 10);
    do_clear();
    push(1);
    drive(0, 1, 0, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 0);
    chk("short_err", err, 1);
    chk("short_busy", busy, 0);

    push(2); push(3);
    drive(0, 1, 0, 2'd0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_result", longint'(result), 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_busy", busy, 0);
    drive(0, 0, 0, 2'd0, 0);
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      int s;
      case ($urandom_range(0, 3))
        0: s = -32768;
        1: s = 32767;
        default: s = int'($signed(16'($urandom)));
      endcase
      drive($urandom_range(0, 1), $urandom_range(0, 3) == 0,
            $urandom_range(0, 23) == 0, 2'($urandom_range(0, 3)), s);
    end
    drive(0, 0, 0, 2'd0, 0);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_stack.md
CAL_STACK -- requirements
Module: cal_stack

Interface
REQ-001 Parameter WIDTH, default 16: signed operand width.
REQ-002 Parameter DEPTH, default 4: operand stack depth, at least 2.
REQ-003 Parameter ACC_W, default WIDTH+$clog2(DEPTH): signed accumulator and result width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 load  input  1  level request to push sample onto the stack.
REQ-008 exec  input  1  level request to start a calculation.
REQ-009 clear  input  1  level request to empty the stack and zero the result.
REQ-010 op  input  2  operation select: 00 ADD, 01 SUB, 10 MAX, 11 MIN.
REQ-011 sample  input  WIDTH  signed two's-complement operand source.
REQ-012 result  output  ACC_W  signed result of the last completed calculation.
REQ-013 count  output  $clog2(DEPTH+1)  number of operands held.
REQ-014 empty, full  output  1 each  count==0, count==DEPTH.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse when result updates.
REQ-017 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-018 Edges: load_e = load & ~load_q, with exec_e and clear_e formed the same way; *_q are registered copies of each input; the action SHALL occur on the same posedge as the edge.
REQ-019 Stack: FIFO-ordered array stk[0..DEPTH-1]; each push writes stk[count] <= sample and count++.
REQ-020 FSM states: IDLE, RUN; busy = (state==RUN).
REQ-021 IDLE, exec_e, count>=2: acc <= sext(stk[0]), idx <= 1, op latched, go RUN.
REQ-022 IDLE, exec_e, count<2: err pulse; no state change.
REQ-023 RUN, each cycle: acc <= acc OP sext(stk[idx]), idx++.
REQ-024 RUN, when idx==count-1: result <= new acc, done pulses in the following cycle, go IDLE; latency = count-1 cycles after the exec_e posedge.
REQ-025 SUB computes stk[0]-stk[1]-...; MAX/MIN are signed compares.
REQ-026 Arithmetic: all operands sign-extended to ACC_W; ACC_W is wide enough that no overflow is possible at any DEPTH, so no saturation is applied.
REQ-027 load_e when full: err pulse; stack and count unchanged.
REQ-028 load_e in RUN: err pulse; no push.
REQ-029 load_e and exec_e on the same posedge in IDLE: exec wins, load is ignored, no err.
REQ-030 clear_e: count <= 0, result <= 0, state <= IDLE, no done; this takes priority over every other event, including mid-RUN.
REQ-031 result and stack contents SHALL hold until the next done or clear; exec does not pop the stack.

Reset
REQ-032 Reset SHALL asynchronously force state=IDLE, count=0, result=0, acc=0, idx=0, all *_q=0, done=0, err=0; stack contents don't-care.
REQ-033 After reset: empty=1, full=0, busy=0.

Structure
REQ-034 Package cal_pkg SHALL hold the op encodings (OP_ADD..OP_MIN) and the FSM state encoding.
REQ-035 A combinational sub-module cal_alu (ACC_W-wide op, a, b -> y) SHALL implement REQ-023/REQ-025.
REQ-036 Edge detection SHALL be inline registers; no edge_detection instances.

Verification (WIDTH=16, DEPTH=4)
REQ-037 Assert reset mid-traffic -> result=0, count=0, empty=1, busy=0 immediately, without waiting for a clk edge.
REQ-038 Push 5, -3, 10; exec, op=ADD -> busy for 2 cycles, done pulse, result=12, count stays 3.
REQ-039 Push 100, 30, 80; exec, op=SUB -> result=-10. Then push 7,-2,9,0 after clear; op=MIN -> -2; op=MAX -> 9.
REQ-040 Push -32768 four times; op=ADD -> result=-131072, no err. A fifth push -> err pulse, count=4.
REQ-041 Start ADD on 4 operands; clear one cycle after exec -> IDLE, result=0, empty=1, no done pulse.
REQ-042 load and exec rise together with count=2 -> calculation runs on 2 operands, count stays 2, no err. exec with count=1 -> err pulse.
